// File: rtl/spi_reg_write_ctrl_pkg.sv
// Purpose: shared motor-controller SPI constants (FSM encodings, command byte, status codes).
// Latency: n/a (constants only).
// Backpressure: n/a.
package spi_reg_write_ctrl_pkg;

  // Frame parser states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_DATA_LO = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  // Command byte that selects a burst write
  localparam logic [7:0] CMD_WRITE = 8'hA5;

  // Frame status codes reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CMD = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;
  localparam logic [1:0] ERR_ODD     = 2'd3;

  // Written-word counter saturates here
  localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/spi_reg_write_ctrl_reg.sv
// Purpose: generic W-bit register with load enable.
// Latency: 1 cycle from d/en to q.
// Backpressure: none; loads whenever en is high.
module spi_reg_write_ctrl_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable, clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/spi_reg_write_ctrl.sv
// Purpose: parse SPI frames (cmd, addr, LE 16-bit words) into auto-incrementing register writes.
// Latency: wr_en one cycle after the hi-byte strobe; status pulse one cycle after rxe.
// Backpressure: none; a byte may arrive every cycle and the register bank must take every write.
module spi_reg_write_ctrl #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] CMD_WRITE = spi_reg_write_ctrl_pkg::CMD_WRITE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rxd,
  input  logic              rxdv,
  input  logic              rxe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy
);

  import spi_reg_write_ctrl_pkg::*;

  logic [2:0]        st_q, st_byte, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_en;
  logic [7:0]        lo_q;
  logic              lo_en;
  logic [7:0]        cnt_q, cnt_byte, cnt_d;
  logic              cnt_en;
  logic              wr_fire, bad_cmd;
  logic              end_ok, end_err;
  logic [1:0]        end_code;

  spi_reg_write_ctrl_reg #(.W(ADDR_W)) u_addr (
    .clk(clk), .rst_n(rst_n), .en(addr_en), .d(addr_d), .q(addr_q)
  );

  spi_reg_write_ctrl_reg #(.W(8)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(lo_en), .d(rxd), .q(lo_q)
  );

  spi_reg_write_ctrl_reg #(.W(8)) u_cnt (
    .clk(clk), .rst_n(rst_n), .en(cnt_en), .d(cnt_d), .q(cnt_q)
  );

  // Byte parsing first, then frame termination judged on the post-byte state
  always_comb begin
    st_byte  = st_q;
    addr_en  = 1'b0;
    addr_d   = addr_q;
    lo_en    = 1'b0;
    wr_fire  = 1'b0;
    bad_cmd  = 1'b0;
    end_ok   = 1'b0;
    end_err  = 1'b0;
    end_code = ERR_NONE;

    if (rxdv) begin
      case (st_q)
        ST_IDLE: begin
          if (rxd == CMD_WRITE) begin
            st_byte = ST_ADDR;
          end else begin
            st_byte = ST_DISCARD;
            bad_cmd = 1'b1;
          end
        end
        ST_ADDR: begin
          addr_en = 1'b1;
          addr_d  = ADDR_W'(rxd);
          st_byte = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          lo_en   = 1'b1;
          st_byte = ST_DATA_HI;
        end
        ST_DATA_HI: begin
          wr_fire = 1'b1;
          addr_en = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          st_byte = ST_DATA_LO;
        end
        default: st_byte = st_q;
      endcase
    end

    cnt_byte = (wr_fire && cnt_q != CNT_MAX) ? cnt_q + 8'd1 : cnt_q;

    if (rxe) begin
      case (st_byte)
        ST_DATA_LO: begin
          if (cnt_byte != 8'd0) begin
            end_ok = 1'b1;
          end else begin
            end_err  = 1'b1;
            end_code = ERR_SHORT;
          end
        end
        ST_ADDR: begin
          end_err  = 1'b1;
          end_code = ERR_SHORT;
        end
        ST_DATA_HI: begin
          end_err  = 1'b1;
          end_code = ERR_ODD;
        end
        ST_DISCARD: begin
          end_err  = 1'b1;
          end_code = ERR_BAD_CMD;
        end
        default: ;
      endcase
    end

    st_d   = rxe ? ST_IDLE : st_byte;
    cnt_en = wr_fire | rxe;
    cnt_d  = rxe ? 8'd0 : cnt_byte;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  // Registered write port; address and data hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 16'h0000;
    end else begin
      wr_en <= wr_fire;
      if (wr_fire) begin
        wr_addr <= addr_q;
        wr_data <= {rxd, lo_q};
      end
    end
  end

  // Status pulses; a bad command byte is flagged as soon as it is seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      frame_ok  <= end_ok;
      frame_err <= end_err;
      if (end_ok || end_err) err_code <= end_code;
      else if (bad_cmd)      err_code <= ERR_BAD_CMD;
    end
  end

  assign busy = (st_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_write_ctrl.sv
// Purpose: randomized frame-level check of spi_reg_write_ctrl against a frame outcome model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_reg_write_ctrl;
  import spi_reg_write_ctrl_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rxd = 8'h00;
  logic              rxdv = 1'b0;
  logic              rxe = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              frame_ok;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;

  spi_reg_write_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rxdv(rxdv), .rxe(rxe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expectations for the outputs visible at the next sampling point
  logic        exp_wr = 1'b0;
  logic [7:0]  exp_addr = 8'h00;
  logic [15:0] exp_data = 16'h0000;
  logic        exp_ok = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_busy = 1'b0;
  logic [1:0]  model_code = ERR_NONE;

  logic [7:0]  fq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic clear_exp(input logic bsy);
    exp_wr   = 1'b0;
    exp_ok   = 1'b0;
    exp_err  = 1'b0;
    exp_busy = bsy;
  endtask

  // Sample at the falling edge, compare, then drive the next inputs
  task automatic step(input logic v, input logic [7:0] d, input logic e);
    @(negedge clk);
    check("wr_en", 32'(wr_en), 32'(exp_wr));
    if (exp_wr) begin
      check("wr_addr", 32'(wr_addr), 32'(exp_addr));
      check("wr_data", 32'(wr_data), 32'(exp_data));
    end
    check("frame_ok", 32'(frame_ok), 32'(exp_ok));
    check("frame_err", 32'(frame_err), 32'(exp_err));
    check("err_code", 32'(err_code), 32'(model_code));
    check("busy", 32'(busy), 32'(exp_busy));
    rxdv = v;
    rxd  = d;
    rxe  = e;
  endtask

  // Drive one frame; the outcome is decided from the byte list as a whole
  task automatic run_frame(input logic [7:0] b[$], input bit joint_in, input bit do_end, input int max_gap);
    int         n;
    bit         good, joint, e, st_ok, st_err;
    logic [1:0] st_code;
    n       = b.size();
    joint   = joint_in && (n > 0);
    good    = (n > 0) && (b[0] == CMD_WRITE);
    st_ok   = 1'b0;
    st_err  = 1'b0;
    st_code = ERR_NONE;
    if (n > 0) begin
      st_err = 1'b1;
      if (!good)                st_code = ERR_BAD_CMD;
      else if (n < 3)           st_code = ERR_SHORT;
      else if ((n - 2) % 2 == 1) st_code = ERR_ODD;
      else begin
        st_err = 1'b0;
        st_ok  = 1'b1;
      end
    end

    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        step(1'b0, 8'h00, 1'b0);
        clear_exp(i > 0);
      end
      e = joint && do_end && (i == n - 1);
      step(1'b1, b[i], e);
      clear_exp(!e);
      // every second data byte completes a word
      if (good && i >= 3 && (i % 2 == 1)) begin
        exp_wr   = 1'b1;
        exp_addr = b[1] + 8'((i - 3) / 2);
        exp_data = {b[i], b[i-1]};
      end
      if (i == 0 && !good) model_code = ERR_BAD_CMD;
      if (e) begin
        exp_ok  = st_ok;
        exp_err = st_err;
        if (st_ok || st_err) model_code = st_code;
      end
    end

    if (do_end && !joint) begin
      repeat ($urandom_range(max_gap, 0)) begin
        step(1'b0, 8'h00, 1'b0);
        clear_exp(n > 0);
      end
      step(1'b0, 8'h00, 1'b1);
      clear_exp(1'b0);
      exp_ok  = st_ok;
      exp_err = st_err;
      if (st_ok || st_err) model_code = st_code;
    end

    if (do_end) begin
      step(1'b0, 8'h00, 1'b0);
      clear_exp(1'b0);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;

    // Two-word burst
    fq = '{8'hA5, 8'h10, 8'h34, 8'h12, 8'h78, 8'h56};
    run_frame(fq, 1'b0, 1'b1, 0);
    // Bad command
    fq = '{8'h3C, 8'h10, 8'h34, 8'h12};
    run_frame(fq, 1'b0, 1'b1, 0);
    // Address only
    fq = '{8'hA5, 8'h20};
    run_frame(fq, 1'b0, 1'b1, 0);
    // Address wrap with odd trailing byte
    fq = '{8'hA5, 8'hFF, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    run_frame(fq, 1'b0, 1'b1, 0);
    // Hi byte coincident with end of frame
    fq = '{8'hA5, 8'h40, 8'hAA, 8'h55};
    run_frame(fq, 1'b1, 1'b1, 0);
    // Empty frame
    fq = {};
    run_frame(fq, 1'b0, 1'b1, 0);

    // Reset in the middle of a frame
    fq = '{8'hA5, 8'h50};
    run_frame(fq, 1'b0, 1'b0, 0);
    step(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_status", 32'({frame_ok, frame_err, err_code}), 32'd0);
    clear_exp(1'b0);
    model_code = ERR_NONE;
    @(negedge clk);
    rst_n = 1'b1;
    fq = '{8'hA5, 8'h60, 8'hEF, 8'hBE};
    run_frame(fq, 1'b0, 1'b1, 0);

    // Random frames
    for (int f = 0; f < 60; f++) begin
      n = $urandom_range(9, 0);
      fq = {};
      for (int i = 0; i < n; i++) begin
        if (i == 0 && $urandom_range(3, 0) != 0) fq.push_back(CMD_WRITE);
        else                                     fq.push_back(8'($urandom_range(255, 0)));
      end
      run_frame(fq, 1'($urandom_range(1, 0)), 1'b1, $urandom_range(2, 0));
    end

    step(1'b0, 8'h00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
